// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states and byte-stream constants.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state and trailing XOR byte).
package prog_loader_pkg;

   localparam int HDR_BYTES = 4;
   localparam int BYTE_W    = 8;

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      CHK,
      DONE,
      ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      DONE,
      ERR
   } state_t;
`endif

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: gathers D_WIDTH/8 bytes little-endian (first byte lands in bits [7:0])
// and presents the finished word with a one-cycle out_valid on the following cycle.
module byte_packer
   import prog_loader_pkg::*;
#(
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               out_valid,
   output logic [D_WIDTH-1:0] out_word
);

   localparam int BPW = D_WIDTH / BYTE_W;
   localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CW-1:0]      byte_cnt;
   logic [D_WIDTH-1:0] acc;
   logic [D_WIDTH-1:0] acc_next;
   logic               last_byte;

   // Merge the incoming byte into its lane of the partially built word.
   always_comb begin
      acc_next = acc;
      acc_next[int'(byte_cnt) * BYTE_W +: BYTE_W] = in_data;
      last_byte = (byte_cnt == CW'(BPW - 1));
   end

   // Advance the byte lane; on the final lane publish the word for exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         byte_cnt  <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_word  <= '0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            if (last_byte) begin
               byte_cnt  <= '0;
               acc       <= '0;
               out_valid <= 1'b1;
               out_word  <= acc_next;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
               acc      <= acc_next;
            end
         end
      end
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed byte stream, writes it word by word into
// instruction memory and holds the core in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR byte checked in CHK).
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int DEPTH   = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     byte_valid,
   input  logic [7:0]               byte_data,
   output logic                     byte_ready,
   output logic                     we,
   output logic [$clog2(DEPTH)-1:0] waddr,
   output logic [D_WIDTH-1:0]       wdata,
   output logic                     core_rst,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);

   state_t             state;
   state_t             state_next;
   logic [1:0]         hdr_cnt;
   logic [23:0]        hdr_lo;
   logic [31:0]        hdr_word;
   logic [AW-1:0]      idx;
   logic [AW-1:0]      last_idx;
   logic               start_load;
   logic               byte_xfer;
   logic               hdr_xfer;
   logic               hdr_last;
   logic               data_xfer;
   logic               len_bad;
   logic               final_write;
   logic               pk_valid;
   logic [D_WIDTH-1:0] pk_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]         chk_xor;
   logic               chk_xfer;
`endif

   // Decode handshakes and header status used by both the FSM and the counters.
   always_comb begin
      start_load  = start && (state == IDLE || state == DONE || state == ERR);
      byte_xfer   = byte_valid && byte_ready;
      hdr_xfer    = byte_xfer && (state == HDR);
      data_xfer   = byte_xfer && (state == DATA);
      hdr_last    = (hdr_cnt == 2'(HDR_BYTES - 1));
      hdr_word    = {byte_data, hdr_lo};
      len_bad     = (hdr_word == 32'd0) || (hdr_word > 32'(DEPTH));
      final_write = pk_valid && (idx == last_idx);
`ifdef LOADER_CHECKSUM_EN
      chk_xfer    = byte_xfer && (state == CHK);
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and byte_ready; ready drops on the last write so no byte slips past the image.
   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      case (state)
         IDLE, DONE, ERR: begin
            if (start_load) begin
               state_next = HDR;
            end
         end
         HDR: begin
            byte_ready = 1'b1;
            if (hdr_xfer && hdr_last) begin
               state_next = len_bad ? ERR : DATA;
            end
         end
         DATA: begin
            byte_ready = !final_write;
            if (final_write) begin
`ifdef LOADER_CHECKSUM_EN
               state_next = CHK;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            byte_ready = 1'b1;
            if (chk_xfer) begin
               state_next = (byte_data == chk_xor) ? DONE : ERR;
            end
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Header assembly and word index; the index saturates at the final word so it never wraps.
   always_ff @(posedge clk) begin
      if (rst || start_load) begin
         hdr_cnt  <= '0;
         hdr_lo   <= '0;
         idx      <= '0;
         last_idx <= '0;
      end else begin
         if (hdr_xfer) begin
            hdr_cnt <= hdr_cnt + 1'b1;
            if (hdr_last) begin
               last_idx <= AW'(hdr_word - 32'd1);
            end else begin
               hdr_lo <= {byte_data, hdr_lo[23:8]};
            end
         end
         if (pk_valid && !final_write) begin
            idx <= idx + 1'b1;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running XOR over every DATA byte, compared against the trailing byte in CHK.
   always_ff @(posedge clk) begin
      if (rst || start_load) begin
         chk_xor <= '0;
      end else if (data_xfer) begin
         chk_xor <= chk_xor ^ byte_data;
      end
   end
`endif

   byte_packer #(
      .D_WIDTH (D_WIDTH)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_load),
      .in_valid  (data_xfer),
      .in_data   (byte_data),
      .out_valid (pk_valid),
      .out_word  (pk_word)
   );

   assign we       = pk_valid;
   assign waddr    = idx;
   assign wdata    = pk_word;
   assign core_rst = (state != DONE);
   assign done     = (state == DONE);
   assign err      = (state == ERR);
   assign busy     = (state == HDR) || (state == DATA)
`ifdef LOADER_CHECKSUM_EN
                     || (state == CHK)
`endif
                     ;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed byte streams, expected writes queued
// by the stimulus side and consumed by an independent write monitor.
module tb_prog_loader;

   localparam int D_WIDTH = 32;
   localparam int DEPTH   = 8;
   localparam int AW      = $clog2(DEPTH);

   typedef struct {
      logic [AW-1:0]      addr;
      logic [D_WIDTH-1:0] data;
   } wr_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_ready;
   logic               we;
   logic [AW-1:0]      waddr;
   logic [D_WIDTH-1:0] wdata;
   logic               core_rst;
   logic               busy;
   logic               done;
   logic               err;

   int          compared   = 0;
   int          mismatched = 0;
   int          writes_seen = 0;
   wr_t         exp_q[$];
   logic [7:0]  stream[$];

   prog_loader #(
      .D_WIDTH (D_WIDTH),
      .DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .core_rst   (core_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expectWrite(input int addr, input logic [D_WIDTH-1:0] data);
      wr_t e;
      e.addr = AW'(addr);
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Write monitor: every we pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && we) begin
         writes_seen++;
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_we: got waddr=%0d wdata=%08h expected no write", waddr, wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            checkOutput("waddr", 64'(waddr), 64'(e.addr));
            checkOutput("wdata", 64'(wdata), 64'(e.data));
         end
      end
   end

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input bit gaps);
      bit ok = 1'b0;
      if (gaps) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      for (int t = 0; t < 50 && !ok; t++) begin
         ok = byte_ready;
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      if (!ok) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL byte_accept_timeout: got ready=0 expected ready=1 for byte %02h", b);
      end
   endtask

   // Sends stream[first..last-1]; optionally raises start alongside one byte.
   task automatic sendRange(input int first, input int last, input bit gaps, input int poke_idx);
      for (int i = first; i < last; i++) begin
         if (i == poke_idx) start = 1'b1;
         sendByte(stream[i], gaps);
         start = 1'b0;
      end
   endtask

   task automatic applyStimulus(input bit gaps, input int poke_idx);
      pulseStart();
      sendRange(0, stream.size(), gaps, poke_idx);
   endtask

   task automatic waitEnd(input string name);
      int t = 0;
      while (!(done || err) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      if (!(done || err)) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s_timeout: got no done/err expected completion", name);
      end
   endtask

   task automatic loadTwoWordStream();
      stream = '{8'h02, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'ha0, 8'h00};
      expectWrite(0, 32'h0050_0093);
      expectWrite(1, 32'h00a0_0113);
   endtask

   task automatic checkDone(input string name, input int writes_before, input int writes_exp);
      checkOutput({name, "_done"}, 64'(done), 64'd1);
      checkOutput({name, "_err"}, 64'(err), 64'd0);
      checkOutput({name, "_core_rst"}, 64'(core_rst), 64'd0);
      checkOutput({name, "_busy"}, 64'(busy), 64'd0);
      checkOutput({name, "_writes"}, 64'(writes_seen - writes_before), 64'(writes_exp));
      checkOutput({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic checkErr(input string name, input int writes_before, input int writes_exp);
      checkOutput({name, "_err"}, 64'(err), 64'd1);
      checkOutput({name, "_done"}, 64'(done), 64'd0);
      checkOutput({name, "_core_rst"}, 64'(core_rst), 64'd1);
      checkOutput({name, "_ready"}, 64'(byte_ready), 64'd0);
      checkOutput({name, "_we"}, 64'(we), 64'd0);
      checkOutput({name, "_writes"}, 64'(writes_seen - writes_before), 64'(writes_exp));
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_ready"}, 64'(byte_ready), 64'd0);
      checkOutput({name, "_we"}, 64'(we), 64'd0);
      checkOutput({name, "_waddr"}, 64'(waddr), 64'd0);
      checkOutput({name, "_wdata"}, 64'(wdata), 64'd0);
      checkOutput({name, "_core_rst"}, 64'(core_rst), 64'd1);
      checkOutput({name, "_busy"}, 64'(busy), 64'd0);
      checkOutput({name, "_done"}, 64'(done), 64'd0);
      checkOutput({name, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      int wb;
      rst        = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkIdle("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] basic two-word load");
      loadTwoWordStream();
      wb = writes_seen;
      pulseStart();
      checkOutput("hdr_busy", 64'(busy), 64'd1);
      checkOutput("hdr_core_rst", 64'(core_rst), 64'd1);
      checkOutput("hdr_ready", 64'(byte_ready), 64'd1);
      sendRange(0, stream.size(), 1'b0, -1);
      waitEnd("basic");
      checkDone("basic", wb, 2);
      checkOutput("basic_waddr_last", 64'(waddr), 64'd1);

      // Bytes held while not ready must do nothing in DONE.
      byte_valid = 1'b1;
      byte_data  = 8'h5a;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("hold_ready", 64'(byte_ready), 64'd0);
      checkOutput("hold_done", 64'(done), 64'd1);
      byte_valid = 1'b0;
      checkOutput("hold_writes", 64'(writes_seen - wb), 64'd2);

      $display("[TB] zero length header");
      stream = '{8'h00, 8'h00, 8'h00, 8'h00};
      wb = writes_seen;
      applyStimulus(1'b0, -1);
      waitEnd("zero");
      checkErr("zero", wb, 0);

      $display("[TB] backpressure gaps with start poked mid-header");
      loadTwoWordStream();
      wb = writes_seen;
      applyStimulus(1'b1, 2);
      waitEnd("gaps");
      checkDone("gaps", wb, 2);

      $display("[TB] reset mid-word");
      loadTwoWordStream();
      wb = writes_seen;
      pulseStart();
      sendRange(0, 10, 1'b0, -1);
      rst = 1'b1;
      @(posedge clk); #1;
      checkIdle("midrst");
      rst = 1'b0;
      checkOutput("midrst_writes", 64'(writes_seen - wb), 64'd1);
      exp_q.delete();
      @(posedge clk); #1;
      loadTwoWordStream();
      wb = writes_seen;
      applyStimulus(1'b0, -1);
      waitEnd("reload");
      checkDone("reload", wb, 2);

      $display("[TB] oversize length");
      stream = '{8'(DEPTH + 1), 8'h00, 8'h00, 8'h00};
      wb = writes_seen;
      applyStimulus(1'b0, -1);
      waitEnd("oversize");
      checkErr("oversize", wb, 0);

      $display("[TB] full depth load");
      stream = '{8'(DEPTH), 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < DEPTH; k++) begin
         logic [7:0] kb;
         logic [7:0] top;
         kb  = 8'(k);
         top = 8'h11 + kb;
         stream.push_back(kb);
         stream.push_back(8'h5a);
         stream.push_back(8'hc3);
         stream.push_back(top);
         expectWrite(k, {top, 8'hc3, 8'h5a, kb});
      end
      wb = writes_seen;
      applyStimulus(1'b0, -1);
      waitEnd("full");
      checkDone("full", wb, DEPTH);
      checkOutput("full_waddr_last", 64'(waddr), 64'(DEPTH - 1));

`ifdef LOADER_CHECKSUM_EN
      // XOR of 93 00 50 00 13 01 a0 00 is 0x71.
      $display("[TB] checksum match");
      loadTwoWordStream();
      stream.push_back(8'h71);
      wb = writes_seen;
      applyStimulus(1'b0, -1);
      waitEnd("chk_ok");
      checkDone("chk_ok", wb, 2);

      $display("[TB] checksum mismatch");
      loadTwoWordStream();
      stream.push_back(8'h00);
      wb = writes_seen;
      applyStimulus(1'b0, -1);
      waitEnd("chk_bad");
      checkErr("chk_bad", wb, 2);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
